// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester bitwise logic unit: opcodes, FSM states
// and the single-bit operation helper used by the datapath.
package logic_unit_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic logic_bit(input op_e op, input logic a, input logic b);
        logic y;
        y = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/nbit_logic.sv
// Purely bitwise combinational ALU slice: each result bit depends only on the
// operand bits at the same position.
module nbit_logic
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  op_e              op,
    output logic [WIDTH-1:0] Y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign Y[gi] = logic_bit(op, A[gi], B[gi]);
        end
    endgenerate

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one shared bitwise logic unit:
// accept in IDLE, compute in EXEC, hold the response in RESP until consumed.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       rst_sync_q;
    logic             run_en;
    logic             last_q, last_d;
    logic             id_q, id_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] alu_y;
    logic             win_id;
    logic             accept;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run_en = rst_sync_q[1];

    // Under contention the requester not served last wins; a lone requester always wins.
    assign win_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_en && (req_valid != 2'b00)) begin
                    accept    = 1'b1;
                    req_ready = win_id ? 2'b10 : 2'b01;
                    state_d   = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    nbit_logic #(
        .WIDTH(WIDTH)
    ) u_logic (
        .A  (a_q),
        .B  (b_q),
        .op (op_q),
        .Y  (alu_y)
    );

    always_comb begin
        last_d = last_q;
        id_d   = id_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        data_d = data_q;
        if (accept) begin
            last_d = win_id;
            id_d   = win_id;
            op_d   = win_id ? op_e'(req_op1) : op_e'(req_op0);
            a_d    = win_id ? req_a1 : req_a0;
            b_d    = win_id ? req_b1 : req_b0;
        end
        if (state_q == EXEC) begin
            data_d = alu_y;
        end
    end

    // Pointer resets to "requester 1 served last" so requester 0 wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
            id_q   <= 1'b0;
            op_q   <= OP_AND;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
        end else begin
            last_q <= last_d;
            id_q   <= id_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            data_q <= data_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: request queues feed the DUT, expected
// responses are queued at issue time and checked by a monitor on each handshake.
module tb_logic_unit_arbiter;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;

    logic [1:0]  n_req_valid, n_req_ready, n_req_op0, n_req_op1;
    logic [7:0]  n_req_a0, n_req_b0, n_req_a1, n_req_b1, n_rsp_data;
    logic        n_rsp_valid, n_rsp_ready, n_rsp_id, n_busy;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_cnt = 0;

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_id = 1'b0;
    logic [31:0] prev_data = '0;

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    logic_unit_arbiter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_op0(n_req_op0), .req_op1(n_req_op1),
        .req_a0(n_req_a0), .req_b0(n_req_b0), .req_a1(n_req_a1), .req_b1(n_req_b1),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_id(n_rsp_id),
        .rsp_data(n_rsp_data), .busy(n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Queue a request for requester r; optionally queue its expected response.
    task automatic issue(input int r, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic expect_rsp, input logic [31:0] exp);
        req_t rq;
        exp_t ex;
        rq.op = op; rq.a = a; rq.b = b;
        if (r == 0) q0.push_back(rq); else q1.push_back(rq);
        if (expect_rsp) begin
            ex.id = r[0]; ex.data = exp;
            sb.push_back(ex);
        end
        $display("issue req%0d op=%0d a=0x%08h b=0x%08h expect=0x%08h", r, op, a, b, exp);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d responses still outstanding", name, sb.size());
        end
    endtask

    // Request driver: presents queue heads, pops on observed acceptance.
    initial begin
        logic a0, a1;
        req_valid = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        forever begin
            @(negedge clk);
            a0 = req_valid[0] && req_ready[0];
            a1 = req_valid[1] && req_ready[1];
            if (a0 || a1) begin
                acc_cyc = cyc;
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            if (a0 && q0.size() > 0) q0.delete(0);
            if (a1 && q1.size() > 0) q1.delete(0);
            req_valid[0] = (q0.size() > 0);
            req_valid[1] = (q1.size() > 0);
            if (q0.size() > 0) begin
                req_op0 = q0[0].op; req_a0 = q0[0].a; req_b0 = q0[0].b;
            end
            if (q1.size() > 0) begin
                req_op1 = q1[0].op; req_a1 = q1[0].a; req_b1 = q1[0].b;
            end
        end
    end

    // Monitor: protocol checks and scoreboard comparison on every response handshake.
    always @(negedge clk) begin
        exp_t ex;
        if (req_ready != 2'b00) begin
            checks++;
            if (req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) begin
                errors++;
                $display("FAIL ready_onehot: got req_ready=%b req_valid=%b", req_ready, req_valid);
            end
        end
        if (rsp_valid && !prev_valid) begin
            check("latency", cyc - acc_cyc, 32'd2);
        end
        if (rsp_valid && prev_valid && !prev_ready) begin
            check("hold_data", rsp_data, prev_data);
            check("hold_id", {31'd0, rsp_id}, {31'd0, prev_id});
            check("hold_busy", {31'd0, busy}, 32'd1);
            check("hold_req_ready", {30'd0, req_ready}, 32'd0);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d data=0x%08h, required no response", rsp_id, rsp_data);
            end else begin
                ex = sb.pop_front();
                $display("rsp id=%0d data=0x%08h (expected id=%0d data=0x%08h)", rsp_id, rsp_data, ex.id, ex.data);
                check("rsp_id", {31'd0, rsp_id}, {31'd0, ex.id});
                check("rsp_data", rsp_data, ex.data);
            end
        end
        prev_valid <= rsp_valid;
        prev_ready <= rsp_ready;
        prev_id    <= rsp_id;
        prev_data  <= rsp_data;
    end

    initial begin
        int start;
        bit seen;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        n_req_valid = 2'b00; n_rsp_ready = 1'b1;
        n_req_op0 = 2'b01; n_req_op1 = 2'b00;
        n_req_a0 = 8'h0F; n_req_b0 = 8'h30; n_req_a1 = '0; n_req_b1 = '0;

        // Contention right after reset: requester 0 must win first.
        issue(0, 2'b01, 32'h12345678, 32'h0F0F0000, 1, 32'h1F3F5678);
        issue(1, 2'b10, 32'hAAAAAAAA, 32'hFFFFFFFF, 1, 32'h55555555);
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_drain("contention");

        // Fairness: both requesters stay valid for six transactions.
        issue(0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 1, 32'h0F0F0000);
        issue(1, 2'b11, 32'hF0F0F0F0, 32'h0000FFFF, 1, 32'h0F0F0000);
        issue(0, 2'b01, 32'h00000001, 32'h80000000, 1, 32'h80000001);
        issue(1, 2'b10, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 32'h21524110);
        issue(0, 2'b10, 32'h12345678, 32'h12345678, 1, 32'h00000000);
        issue(1, 2'b00, 32'hCAFEBABE, 32'h00FF00FF, 1, 32'h00FE00BE);
        wait_drain("fairness");

        // Single request from requester 0.
        issue(0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000);
        wait_drain("single");

        // Backpressure: NOR of zeros held in RESP while requester 0 waits.
        rsp_ready = 1'b0;
        issue(1, 2'b11, 32'h00000000, 32'h00000000, 1, 32'hFFFFFFFF);
        issue(0, 2'b10, 32'h0000FFFF, 32'h00FF00FF, 1, 32'h00FFFF00);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL backpressure_wait: rsp_valid never rose within 50 cycles");
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_drain("backpressure");

        // Reset while the accepted request is in EXEC: it must vanish.
        issue(0, 2'b00, 32'hFFFFFFFF, 32'h12345678, 0, 32'h00000000);
        start = acc_cnt;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc_cnt != start) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL midreset_accept: request not accepted within 50 cycles");
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rsp_data", rsp_data, 32'd0);
        check("midreset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("midreset_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
        issue(0, 2'b00, 32'hFFFFFFFF, 32'h12345678, 1, 32'h12345678);
        wait_drain("midreset_replay");

        // 8-bit instance: OR.
        @(posedge clk); #1 n_req_valid = 2'b01;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_req_ready[0]) begin seen = 1; break; end
        end
        @(posedge clk); #1 n_req_valid = 2'b00;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL w8_accept: request not accepted within 20 cycles");
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_rsp_valid) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL w8_rsp: rsp_valid never rose within 20 cycles");
        end else begin
            $display("rsp8 id=%0d data=0x%02h (expected id=0 data=0x3f)", n_rsp_id, n_rsp_data);
            check("w8_rsp_data", {24'd0, n_rsp_data}, 32'h3F);
            check("w8_rsp_id", {31'd0, n_rsp_id}, 32'd0);
        end
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
